// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed
    } state_e;

    // Index of the single set bit; 0 when none is set.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Column bit 0 is the leftmost keypad column; col_oh is active-high.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [3:0] col_oh);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, onehot_to_idx(col_oh)})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-stage synchronizer for the asynchronous keypad column returns.
module sync_2ff #(
    parameter int unsigned          WIDTH       = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobe, debounce, hex encode and 4-digit key history.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] digit_3,
    output logic [3:0] digit_4
);

    localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] col_s;

    sync_2ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'hF)
    ) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (col),
        .q     (col_s)
    );

    state_e            state_q, state_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [3:0]        cand_col_q, cand_col_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0][3:0]   digits_q, digits_d;

    logic [3:0] col_low;
    logic       single_low;
    logic [3:0] new_code;

    assign col_low    = ~col_s;
    assign single_low = (col_low != 4'h0) && ((col_low & (col_low - 4'h1)) == 4'h0);
    assign new_code   = key_map(cand_row_q, ~cand_col_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StScan;
            row_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            cand_row_q  <= 2'd0;
            cand_col_q  <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            digits_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            digits_q    <= digits_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        digits_d    = digits_q;

        case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (single_low) begin
                        // Hold the row so the same key keeps driving col during debounce.
                        cand_row_d = row_idx_q;
                        cand_col_d = col_s;
                        deb_d      = '0;
                        state_d    = StDebounce;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            StDebounce: begin
                if (col_s == cand_col_q) begin
                    if (deb_q == DebLast) begin
                        state_d     = StPressed;
                        deb_d       = '0;
                        key_valid_d = 1'b1;
                        key_code_d  = new_code;
                        digits_d    = {digits_q[2:0], new_code};
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    state_d   = StScan;
                    row_idx_d = row_idx_q + 2'd1;
                    dwell_d   = '0;
                end
            end

            StPressed: begin
                // Any other key on the frozen row just keeps the release count at zero.
                if (col_s == 4'hF) begin
                    if (deb_q == DebLast) begin
                        state_d   = StScan;
                        deb_d     = '0;
                        row_idx_d = row_idx_q + 2'd1;
                        dwell_d   = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = '0;
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase
    end

    assign row       = ~(4'b0001 << row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == StPressed);
    assign digit_1   = digits_q[0];
    assign digit_2   = digits_q[1];
    assign digit_3   = digits_q[2];
    assign digit_4   = digits_q[3];

endmodule
